// File: rtl/fir_da_pkg.sv
// Shared types, default parameters and arithmetic helpers for the
// bit-serial distributed-arithmetic FIR engine.
package fir_da_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_TAPS      = 64;
    localparam int DEF_LUT_IN    = 8;
    localparam int DEF_LUT_W     = 24;
    localparam int DEF_OUT_W     = 32;
    localparam int DEF_OUT_SHIFT = 0;

    // Wide enough for any accumulator plus rounding headroom.
    localparam int WIDE_W = 128;

    // clog2 that never returns zero, so one-entry selects still get a port bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width: LUT sum growth over GROUPS plus DATA_W bit weights.
    function automatic int acc_width(input int lut_w, input int data_w, input int groups);
        return lut_w + data_w + $clog2(groups);
    endfunction

    // Arithmetic shift right, round half up, then clamp to a signed out_w range.
    function automatic logic signed [WIDE_W-1:0] round_sat(
        input logic signed [WIDE_W-1:0] val,
        input int                       shift,
        input int                       out_w
    );
        logic signed [WIDE_W-1:0] half;
        logic signed [WIDE_W-1:0] one;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        logic signed [WIDE_W-1:0] r;
        one       = '0;
        one[0]    = 1'b1;
        half      = '0;
        if (shift > 0) begin
            half = one <<< (shift - 1);
        end
        r         = (val + half) >>> shift;
        hi        = '0;
        hi[out_w-1] = 1'b1;
        lo        = -hi;
        hi        = hi - one;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_da_lut.sv
// One DA group's partial-sum table: synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded filter survives reset.
module fir_da_lut
    import fir_da_pkg::*;
#(
    parameter int LUT_IN = DEF_LUT_IN,
    parameter int LUT_W  = DEF_LUT_W
) (
    input  logic                     clk3,
    input  logic                     we,
    input  logic [LUT_IN-1:0]        waddr,
    input  logic signed [LUT_W-1:0]  wdata,
    input  logic [LUT_IN-1:0]        raddr,
    output logic signed [LUT_W-1:0]  rdata
);

    logic signed [LUT_W-1:0] mem [2**LUT_IN];

    // Table write port.
    always_ff @(posedge clk3) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_da_stream.sv
// Bit-serial distributed-arithmetic FIR with valid/ready streaming ports,
// run-time loadable group LUTs, and a rounded, saturated registered output.
module fir_da_stream
    import fir_da_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAPS      = DEF_TAPS,
    parameter int LUT_IN    = DEF_LUT_IN,
    parameter int LUT_W     = DEF_LUT_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic                                     clk3,
    input  logic                                     areset_n,
    input  logic signed [DATA_W-1:0]                 in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic signed [OUT_W-1:0]                  out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    input  logic                                     flush,
    input  logic                                     lut_we,
    input  logic [clog2_min1(TAPS/LUT_IN)-1:0]       lut_grp,
    input  logic [LUT_IN-1:0]                        lut_addr,
    input  logic signed [LUT_W-1:0]                  lut_data,
    output logic                                     lut_err
);

    localparam int GROUPS = TAPS / LUT_IN;
    localparam int GRP_W  = clog2_min1(GROUPS);
    localparam int ACC_W  = acc_width(LUT_W, DATA_W, GROUPS);
    localparam int SUM_W  = LUT_W + clog2_min1(GROUPS);
    localparam int CNT_W  = clog2_min1(DATA_W);

    state_t                   state;
    state_t                   next_state;
    logic [DATA_W-1:0]        taps [TAPS];
    logic [CNT_W-1:0]         bit_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  term;
    logic signed [SUM_W-1:0]  lut_sum;
    logic signed [WIDE_W-1:0] acc_wide;
    logic [LUT_IN-1:0]        lut_raddr [GROUPS];
    logic signed [LUT_W-1:0]  lut_rdata [GROUPS];
    logic                     accept;
    logic                     last_bit;
    logic                     lut_wr_ok;

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign lut_wr_ok = lut_we && (state == IDLE) && !flush;
    assign acc_wide  = {{(WIDE_W - ACC_W){acc_next[ACC_W-1]}}, acc_next};

    for (genvar g = 0; g < GROUPS; g++) begin : g_lut
        fir_da_lut #(
            .LUT_IN (LUT_IN),
            .LUT_W  (LUT_W)
        ) u_lut (
            .clk3  (clk3),
            .we    (lut_wr_ok && (lut_grp == GRP_W'(g))),
            .waddr (lut_addr),
            .wdata (lut_data),
            .raddr (lut_raddr[g]),
            .rdata (lut_rdata[g])
        );
    end

    // State register.
    always_ff @(posedge clk3 or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs; flush always returns to IDLE.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                if (last_bit) begin
                    next_state = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // Delay line: newest sample enters tap 0, flush clears every tap.
    always_ff @(posedge clk3 or negedge areset_n) begin
        if (!areset_n) begin
            for (int k = 0; k < TAPS; k++) begin
                taps[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) begin
                taps[k] <= '0;
            end
        end else if (accept) begin
            taps[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    // Each group's LUT address is the current bit slice across its taps.
    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            lut_raddr[g] = '0;
            for (int j = 0; j < LUT_IN; j++) begin
                lut_raddr[g][j] = taps[g*LUT_IN + j][bit_cnt];
            end
        end
    end

    // Adder tree over groups, weighted by 2^bit; the sign bit subtracts.
    always_comb begin
        lut_sum = '0;
        for (int g = 0; g < GROUPS; g++) begin
            lut_sum = lut_sum + {{(SUM_W - LUT_W){lut_rdata[g][LUT_W-1]}}, lut_rdata[g]};
        end
        term     = {{(ACC_W - SUM_W){lut_sum[SUM_W-1]}}, lut_sum};
        term     = term <<< bit_cnt;
        acc_next = last_bit ? (acc - term) : (acc + term);
    end

    // Bit counter and accumulator advance once per CALC cycle.
    always_ff @(posedge clk3 or negedge areset_n) begin
        if (!areset_n) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else if (accept) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else if (flush) begin
            bit_cnt <= '0;
        end else if (state == CALC) begin
            acc     <= acc_next;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

    // Result register captures the final sum; dropped LUT writes flag an error.
    always_ff @(posedge clk3 or negedge areset_n) begin
        if (!areset_n) begin
            out_data <= '0;
            lut_err  <= 1'b0;
        end else begin
            lut_err <= lut_we && !lut_wr_ok;
            if ((state == CALC) && last_bit && !flush) begin
                out_data <= OUT_W'(round_sat(acc_wide, OUT_SHIFT, OUT_W));
            end
        end
    end

endmodule

// File: doc/fir_da_stream.md
# fir_da_stream

Parametrised, single-clock, bit-serial distributed-arithmetic (DA) FIR engine with a streaming valid/ready interface.

- Replaces the fixed 64-tap, 16-bit, free-running-load FIR core.
- Tap count, sample width, LUT grouping and output scaling are parameters.
- DA partial-sum LUTs are loaded at run time.
- Output is rounded and saturated.
- Sits between the input FIFO read side and downstream consumers, all in the DA clock domain.

## Interface
Parameters:
- DATA_W, 16: signed input sample width; also the bit-serial cycles per output.
- TAPS, 64: filter length; must be a multiple of LUT_IN.
- LUT_IN, 8: taps per DA group; GROUPS = TAPS/LUT_IN.
- LUT_W, 24: signed LUT entry width.
- OUT_W, 32: signed output width.
- OUT_SHIFT, 0: arithmetic right shift applied before rounding and saturation.

Ports:
- clk3, in, 1: sole clock, rising edge.
- areset_n, in, 1: asynchronous, active-low reset.
- in_data, in, DATA_W: signed sample.
- in_valid, in, 1: sample offered.
- in_ready, out, 1: sample can be accepted.
- out_data, out, OUT_W: filtered sample.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: consumer accepts out_data.
- flush, in, 1: synchronous clear of the delay line.
- lut_we, in, 1: LUT write strobe.
- lut_grp, in, clog2(GROUPS): LUT group select.
- lut_addr, in, LUT_IN: LUT entry address.
- lut_data, in, LUT_W: LUT entry value.
- lut_err, out, 1: one-cycle pulse when a LUT write is dropped.

## Operation
States: IDLE, CALC, OUT.

**Reset (areset_n=0):**
- State goes to IDLE.
- Delay line and accumulator are cleared.
- bit_cnt=0.
- Outputs: in_ready=1, out_valid=0, out_data=0, lut_err=0.
- LUT contents are not reset.

**IDLE:**
- in_ready=1.
- On in_valid&in_ready:
  - The delay line shifts: tap0 ← in_data, tap k ← tap k-1, and tap TAPS-1 is discarded.
  - acc ← 0, bit_cnt ← 0, state → CALC.

**CALC:**
- in_ready=0.
- Each cycle processes bit b=bit_cnt, LSB first.
- Address for group g: address bit j = bit b of tap (g·LUT_IN + j).
- S = signed sum of the GROUPS LUT outputs.
- acc ← acc + (S << b) for b < DATA_W-1.
- acc ← acc − (S << b) for b = DATA_W-1 (two's-complement sign bit).
- After the bit DATA_W-1 cycle, state → OUT.

**Accumulator and output width:**
- acc width is LUT_W + DATA_W + clog2(GROUPS); it never overflows.
- out_data = sat_OUT_W(round_half_up(acc >>> OUT_SHIFT)).
- Saturation clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].

**OUT:**
- out_valid=1 and out_data is held stable until out_ready.
- On out_valid&out_ready: out_valid ← 0, state → IDLE.

**flush:**
- Clears all taps.
- Aborts CALC or OUT: out_valid ← 0, state → IDLE.
- flush wins over a same-cycle input accept (the sample is dropped).

**LUT writes:**
- Accepted only in IDLE with flush=0: lut[lut_grp][lut_addr] ← lut_data.
- In CALC or OUT the write is dropped and lut_err pulses for 1 cycle.
- An accept and a LUT write in the same IDLE cycle are both performed; the computation uses the new entry.

**Reset mid-CALC or mid-OUT:** the result is discarded and the state is as after reset.

## Timing
- The accept edge is t0.
- CALC occupies the edges t0+1 … t0+DATA_W.
- out_valid is high after edge t0+DATA_W, i.e. a DATA_W-cycle result latency.
- out_data is registered; no combinational path from in_* to out_*.
- Minimum sample period is DATA_W+2 cycles (IDLE, DATA_W×CALC, OUT) with out_ready held high.
- Backpressure: in_ready stays 0 for as long as out_ready=0 in OUT.
- LUT read is asynchronous within the CALC cycle; LUT write is synchronous.

## Structure
- Package fir_da_pkg holds:
  - the state enum (IDLE/CALC/OUT);
  - default parameter constants;
  - the function computing acc width;
  - the sat/round helper function.
- Sub-module fir_da_lut: one group's 2^LUT_IN × LUT_W RAM with synchronous write and asynchronous read. It is instantiated GROUPS times in a generate loop.
- The top level contains the delay line, bit_cnt, FSM, adder tree, accumulator and output stage.

## Test plan
1. **Unit impulse at tap 0.** Load group-0 LUT with LUT[a] = a[0]; all other LUTs 0. Inputs 100, then −5 → out_data 100, then −5, each out_valid exactly DATA_W cycles after accept.
2. **Delayed coefficient.** Coefficient h3=2 (group-0 LUT[a] = 2·a[3]). Inputs 7,0,0,0 → outputs 0,0,0,14.
3. **Saturation.** All h=1 with OUT_W=16. Feed 64 samples of 32767 → final output clamps to 32767. Feed −32768 ×64 → −32768.
4. **Backpressure.** Hold out_ready=0 for 10 cycles in OUT → out_data stable, in_ready=0, no sample lost. Then release → next accept occurs 1 cycle after the handshake.
5. **Dropped LUT write and flush.** LUT write during CALC → lut_err single pulse, LUT unchanged. flush asserted during CALC → out_valid stays 0, and the next output uses only new samples.
6. **Async reset mid-CALC.** Assert async reset in the middle of CALC → in_ready=1 and out_valid=0 immediately. A prior LUT load is retained: the scenario 1 input after reset still gives 100.
